// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types, defaults and lane mapping for axis_width_packer (PACKER_MSB_FIRST_EN)
package axis_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_RATIO = 4;
  localparam int DEF_CNT_W = 16;

  // Output lane that input beat number idx of a word lands in.
  function automatic int lane_of(input int idx, input int ratio);
`ifdef PACKER_MSB_FIRST_EN
    return ratio - 1 - idx;
`else
    return idx + 0 * ratio;
`endif
  endfunction

endpackage

// File: rtl/axis_width_packer_if.sv
// rtl/axis_width_packer_if.sv - narrow input stream and packed output stream bundle
interface axis_width_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  localparam int OUT_W = IN_W * RATIO;

  logic [IN_W-1:0]  s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [OUT_W-1:0] m_tdata;
  logic [RATIO-1:0] m_tkeep;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid
  );
endinterface

// File: rtl/axis_msg_counter.sv
// rtl/axis_msg_counter.sv - saturating per-message word counter with clear-then-increment
module axis_msg_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      // A word leaving in the clearing cycle is the first word of the new message.
      count <= {{(CNT_W-1){1'b0}}, inc};
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axis_width_packer.sv
// rtl/axis_width_packer.sv - packs RATIO narrow beats per wide word; lane order set by PACKER_MSB_FIRST_EN
module axis_width_packer
  import axis_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int RATIO = DEF_RATIO,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upsizing,
  input  logic                clear_msg_count,
  axis_width_packer_if.slave  bus,
  output logic [CNT_W-1:0]    msg_count
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  packer_state_t    state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             mode, mode_n;
  logic [OUT_W-1:0] acc_data, acc_data_n;
  logic [RATIO-1:0] acc_keep, acc_keep_n;
  logic [OUT_W-1:0] out_data, out_data_n;
  logic [RATIO-1:0] out_keep, out_keep_n;
  logic             out_last, out_last_n;

  logic             s_ready;
  logic             beat_acc;
  logic             xfer;
  logic [IDX_W-1:0] beat_idx;
  logic             beat_mode;
  logic             complete;
  int               lane;
  logic [OUT_W-1:0] beat_data;
  logic [RATIO-1:0] beat_keep;

  always_comb begin
    s_ready   = (state == FILL) || bus.m_tready;
    beat_acc  = bus.s_tvalid && s_ready;
    xfer      = (state == HOLD) && bus.m_tready;
    // A beat taken while a word is leaving always starts the next word.
    beat_idx  = (state == HOLD) ? '0 : idx;
    beat_mode = (beat_idx == '0) ? upsizing : mode;
    lane      = lane_of(int'(beat_idx), RATIO);
    beat_data = (state == HOLD) ? '0 : acc_data;
    beat_keep = (state == HOLD) ? '0 : acc_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (k == lane) begin
        beat_data[k*IN_W +: IN_W] = bus.s_tdata;
        beat_keep[k]              = 1'b1;
      end
    end
    complete = !beat_mode || (beat_idx == LAST_IDX) || bus.s_tlast;
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    mode_n     = mode;
    acc_data_n = acc_data;
    acc_keep_n = acc_keep;
    out_data_n = out_data;
    out_keep_n = out_keep;
    out_last_n = out_last;
    unique case (state)
      FILL: begin
        if (beat_acc) begin
          mode_n = beat_mode;
          if (complete) begin
            out_data_n = beat_data;
            out_keep_n = beat_keep;
            out_last_n = bus.s_tlast;
            acc_data_n = '0;
            acc_keep_n = '0;
            idx_n      = '0;
            state_n    = HOLD;
          end else begin
            acc_data_n = beat_data;
            acc_keep_n = beat_keep;
            idx_n      = idx + 1'b1;
          end
        end
      end
      HOLD: begin
        if (xfer) begin
          if (beat_acc && complete) begin
            out_data_n = beat_data;
            out_keep_n = beat_keep;
            out_last_n = bus.s_tlast;
            mode_n     = beat_mode;
          end else begin
            out_data_n = '0;
            out_keep_n = '0;
            out_last_n = 1'b0;
            state_n    = FILL;
            if (beat_acc) begin
              acc_data_n = beat_data;
              acc_keep_n = beat_keep;
              idx_n      = IDX_W'(1);
              mode_n     = beat_mode;
            end
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      idx      <= '0;
      mode     <= 1'b0;
      acc_data <= '0;
      acc_keep <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      mode     <= mode_n;
      acc_data <= acc_data_n;
      acc_keep <= acc_keep_n;
      out_data <= out_data_n;
      out_keep <= out_keep_n;
      out_last <= out_last_n;
    end
  end

  assign bus.s_tready = s_ready;
  assign bus.m_tvalid = (state == HOLD);
  assign bus.m_tdata  = out_data;
  assign bus.m_tkeep  = out_keep;
  assign bus.m_tlast  = out_last;

  axis_msg_counter #(.CNT_W(CNT_W)) u_msg_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_msg_count),
    .inc   (xfer),
    .count (msg_count)
  );

endmodule

// File: tb/tb_axis_width_packer.sv
// tb/tb_axis_width_packer.sv - directed and randomized checks of axis_width_packer against a word-level model
module tb_axis_width_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int CNT_W = 16;
  localparam int OUT_W = IN_W * RATIO;

  typedef struct packed {
    logic             last;
    logic [RATIO-1:0] keep;
    logic [OUT_W-1:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             upsizing = 1'b1;
  logic             clear_msg_count = 1'b0;
  logic [CNT_W-1:0] msg_count;

  axis_width_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();

  axis_width_packer #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .upsizing        (upsizing),
    .clear_msg_count (clear_msg_count),
    .bus             (bus),
    .msg_count       (msg_count)
  );

  always #5 clk = ~clk;

  word_t            exp_q[$];
  word_t            got_q[$];
  int               checks = 0;
  int               fails = 0;
  int               exp_cnt = 0;
  bit               rnd_ready = 0;
  int               m_n = 0;
  bit               m_mode = 0;
  logic [OUT_W-1:0] m_data = '0;
  logic [RATIO-1:0] m_keep = '0;

  // Outputs sampled mid-cycle: a word seen valid and ready here leaves at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.m_tvalid && bus.m_tready)
      got_q.push_back('{last: bus.m_tlast, keep: bus.m_tkeep, data: bus.m_tdata});
  end

  function automatic int tb_lane(input int i);
`ifdef PACKER_MSB_FIRST_EN
    return RATIO - 1 - i;
`else
    return i;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [IN_W-1:0] d, input bit l, input bit up);
    int ln;
    if (m_n == 0) m_mode = up;
    ln = m_mode ? tb_lane(m_n) : tb_lane(0);
    m_data[ln*IN_W +: IN_W] = d;
    m_keep[ln] = 1'b1;
    m_n++;
    if (!m_mode || m_n == RATIO || l) begin
      exp_q.push_back('{last: l, keep: m_keep, data: m_data});
      exp_cnt++;
      m_n = 0;
      m_data = '0;
      m_keep = '0;
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_data = '0;
    m_keep = '0;
    exp_cnt = 0;
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input bit l);
    int n;
    bit done;
    n = 0;
    done = 0;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    bus.s_tvalid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = bus.s_tready;
      @(posedge clk);
      #1;
      if (rnd_ready) bus.m_tready = ($urandom_range(0, 3) != 0);
      n++;
    end
    bus.s_tvalid = 1'b0;
    chk("beat_accepted", 64'(done), 64'd1);
    if (done) model_beat(d, l, upsizing);
  endtask

  task automatic drain_and_compare();
    int n;
    word_t g, e;
    bus.m_tready = 1'b1;
    n = 0;
    while (n < 300 && (bus.m_tvalid || got_q.size() != exp_q.size())) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_in_time", 64'(n < 300), 64'd1);
    chk("word_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk("word_data", 64'(g.data), 64'(e.data));
      chk("word_keep", 64'(g.keep), 64'(e.keep));
      chk("word_last", 64'(g.last), 64'(e.last));
    end
    got_q.delete();
    exp_q.delete();
    chk("msg_count", 64'(msg_count), 64'(exp_cnt));
  endtask

  task automatic pulse_clear();
    clear_msg_count = 1'b1;
    @(posedge clk);
    #1;
    clear_msg_count = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    word_t w;
    logic [OUT_W-1:0] c_a, c_b, c_c;
    logic [RATIO-1:0] k_b, k_c;
`ifdef PACKER_MSB_FIRST_EN
    c_a = 32'h11223344; c_b = 32'hAABB0000; k_b = 4'b1100; c_c = 32'h01000000; k_c = 4'b1000;
`else
    c_a = 32'h44332211; c_b = 32'h0000BBAA; k_b = 4'b0011; c_c = 32'h00000001; k_c = 4'b0001;
`endif
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(bus.m_tdata), 64'd0);
    chk("rst_m_tkeep", 64'(bus.m_tkeep), 64'd0);
    chk("rst_m_tlast", 64'(bus.m_tlast), 64'd0);
    chk("rst_msg_count", 64'(msg_count), 64'd0);
    chk("rst_s_tready", 64'(bus.s_tready), 64'd1);
    @(posedge clk);
    #1;

    // Full word with tlast on the fourth beat.
    upsizing = 1'b1;
    send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 1);
    drain_and_compare_a : begin
      int n;
      n = 0;
      while (n < 50 && got_q.size() < 1) begin @(negedge clk); n++; end
      w = got_q[0];
      chk("a_data", 64'(w.data), 64'(c_a));
      chk("a_keep", 64'(w.keep), 64'hF);
      chk("a_last", 64'(w.last), 64'd1);
    end
    drain_and_compare();

    // Partial word flushed by tlast.
    send_beat(8'hAA, 0); send_beat(8'hBB, 1);
    drain_and_compare_b : begin
      int n;
      n = 0;
      while (n < 50 && got_q.size() < 1) begin @(negedge clk); n++; end
      w = got_q[0];
      chk("b_data", 64'(w.data), 64'(c_b));
      chk("b_keep", 64'(w.keep), 64'(k_b));
      chk("b_last", 64'(w.last), 64'd1);
    end
    drain_and_compare();
    pulse_clear();
    @(negedge clk);
    chk("clear_alone_a", 64'(msg_count), 64'd0);
    @(posedge clk);
    #1;

    // Pass-through mode.
    upsizing = 1'b0;
    send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0);
    drain_and_compare_c : begin
      int n;
      n = 0;
      while (n < 50 && got_q.size() < 1) begin @(negedge clk); n++; end
      w = got_q[0];
      chk("c_data", 64'(w.data), 64'(c_c));
      chk("c_keep", 64'(w.keep), 64'(k_c));
    end
    drain_and_compare();

    // Downstream stall while a word is held and the next beat is waiting.
    upsizing = 1'b1;
    bus.m_tready = 1'b0;
    send_beat(8'hA1, 0); send_beat(8'hA2, 0); send_beat(8'hA3, 0); send_beat(8'hA4, 1);
    bus.s_tdata  = 8'h55;
    bus.s_tlast  = 1'b0;
    bus.s_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_m_tvalid", 64'(bus.m_tvalid), 64'd1);
      chk("stall_m_tdata", 64'(bus.m_tdata), 64'(exp_q[0].data));
      chk("stall_m_tkeep", 64'(bus.m_tkeep), 64'(exp_q[0].keep));
      chk("stall_s_tready", 64'(bus.s_tready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.m_tready = 1'b1;
    send_beat(8'h55, 0); send_beat(8'h66, 0); send_beat(8'h77, 0); send_beat(8'h88, 1);
    drain_and_compare();

    // Clear coinciding with a transfer at count 7, then clear alone.
    pulse_clear();
    upsizing = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(8'(8'h60 + i), 0);
    drain_and_compare();
    bus.m_tready = 1'b0;
    send_beat(8'h70, 0);
    clear_msg_count = 1'b1;
    bus.m_tready = 1'b1;
    @(posedge clk);
    #1;
    clear_msg_count = 1'b0;
    @(negedge clk);
    chk("clear_with_xfer", 64'(msg_count), 64'd1);
    exp_cnt = 1;
    @(posedge clk);
    #1;
    pulse_clear();
    @(negedge clk);
    chk("clear_alone_b", 64'(msg_count), 64'd0);
    drain_and_compare();

    // Reset in the middle of a word.
    upsizing = 1'b1;
    send_beat(8'h01, 0); send_beat(8'h02, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("midrst_msg_count", 64'(msg_count), 64'd0);
    @(posedge clk);
    #1;
    send_beat(8'h05, 0); send_beat(8'h06, 0); send_beat(8'h07, 0); send_beat(8'h08, 0);
    drain_and_compare();

    // Random beats, random mode per beat, random downstream backpressure.
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      upsizing = 1'($urandom_range(0, 1));
      send_beat(8'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    send_beat(8'hEE, 1);
    rnd_ready = 0;
    drain_and_compare();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
